// File: rtl/instruction_memory_arbiter.sv
// Arbitrates the single-port instruction memory between the fetch stage and the program loader.
// Reads return data one cycle later; the loader waits on loaderReady and is forced through after STARVE_LIMIT denials.
module instruction_memory_arbiter #(
  parameter int ADDR_WIDTH   = 10,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  fetchEnable,
  input  logic [31:0]           fetchAddress,
  output logic                  fetchStall,
  output logic [31:0]           fetchData,
  output logic                  fetchDataValid,
  input  logic                  loaderValid,
  input  logic [31:0]           loaderAddress,
  input  logic [31:0]           loaderData,
  output logic                  loaderReady,
  input  logic                  loaderDone,
  output logic                  bootDone,
  output logic [ADDR_WIDTH-1:0] memAddress,
  output logic                  memWriteEnable,
  output logic [31:0]           memWriteData,
  input  logic [31:0]           memReadData
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  typedef enum logic {BOOT, RUN} state_t;

  state_t        state, stateNext;
  logic [SW-1:0] starveCount, starveNext;
  logic          fetchDataValidNext;
  logic          loaderGrant;
  logic          unusedAddrBits;

  // Only word-address bits reach the macro: high bits wrap, low bits round down.
  assign unusedAddrBits = ^{fetchAddress[31:ADDR_WIDTH+2], fetchAddress[1:0],
                            loaderAddress[31:ADDR_WIDTH+2], loaderAddress[1:0]};

  assign fetchData = memReadData;

  always_comb begin
    stateNext          = state;
    starveNext         = '0;
    fetchDataValidNext = 1'b0;
    loaderGrant        = 1'b0;
    fetchStall         = 1'b1;
    loaderReady        = 1'b1;
    bootDone           = 1'b0;
    memWriteEnable     = 1'b0;
    memAddress         = loaderAddress[ADDR_WIDTH+1:2];
    memWriteData       = loaderData;

    case (state)
      BOOT: begin
        memWriteEnable = loaderValid;
        if (loaderDone) stateNext = RUN;
      end
      RUN: begin
        bootDone    = 1'b1;
        loaderGrant = loaderValid & (!fetchEnable | (starveCount >= LIMIT));
        if (loaderGrant) begin
          memWriteEnable = 1'b1;
          fetchStall     = fetchEnable;
        end else begin
          fetchStall  = 1'b0;
          loaderReady = 1'b0;
          memAddress  = fetchAddress[ADDR_WIDTH+1:2];
        end
        if (loaderValid && !loaderGrant)
          starveNext = (starveCount >= LIMIT) ? starveCount : starveCount + 1'b1;
        fetchDataValidNext = fetchEnable & !loaderGrant;
      end
      default: stateNext = BOOT;
    endcase

    // The write strobe must not fire while reset holds the block.
    if (reset) begin
      memWriteEnable = 1'b0;
      fetchStall     = 1'b1;
      loaderReady    = 1'b1;
      bootDone       = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= BOOT;
      starveCount    <= '0;
      fetchDataValid <= 1'b0;
    end else begin
      state          <= stateNext;
      starveCount    <= starveNext;
      fetchDataValid <= fetchDataValidNext;
    end
  end

endmodule

// File: tb/tb_instruction_memory_arbiter.sv
// Directed bench: behavioural memory macro, scoreboard of expected fetch words popped by a monitor.
module tb_instruction_memory_arbiter;

  localparam int ADDR_WIDTH   = 10;
  localparam int STARVE_LIMIT = 4;

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  fetchEnable;
  logic [31:0]           fetchAddress;
  logic                  fetchStall;
  logic [31:0]           fetchData;
  logic                  fetchDataValid;
  logic                  loaderValid;
  logic [31:0]           loaderAddress;
  logic [31:0]           loaderData;
  logic                  loaderReady;
  logic                  loaderDone;
  logic                  bootDone;
  logic [ADDR_WIDTH-1:0] memAddress;
  logic                  memWriteEnable;
  logic [31:0]           memWriteData;
  logic [31:0]           memReadData;

  logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];
  logic [31:0] expQ [$];
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  instruction_memory_arbiter #(.ADDR_WIDTH(ADDR_WIDTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clock(clock), .reset(reset),
    .fetchEnable(fetchEnable), .fetchAddress(fetchAddress), .fetchStall(fetchStall),
    .fetchData(fetchData), .fetchDataValid(fetchDataValid),
    .loaderValid(loaderValid), .loaderAddress(loaderAddress), .loaderData(loaderData),
    .loaderReady(loaderReady), .loaderDone(loaderDone), .bootDone(bootDone),
    .memAddress(memAddress), .memWriteEnable(memWriteEnable), .memWriteData(memWriteData),
    .memReadData(memReadData)
  );

  // Single-port synchronous memory macro model.
  always @(posedge clock) begin
    if (memWriteEnable) mem[memAddress] <= memWriteData;
    memReadData <= mem[memAddress];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every valid fetch word must match the oldest expected word.
  always @(negedge clock) begin
    if (fetchDataValid) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("FAIL fetch_unexpected: got 0x%0h expected no valid word at %0t", fetchData, $time);
      end else begin
        logic [31:0] e;
        e = expQ.pop_front();
        if (fetchData !== e) begin
          errors++;
          $display("FAIL fetch_data: got 0x%0h expected 0x%0h at %0t", fetchData, e, $time);
        end
      end
    end
  end

  task automatic idle();
    fetchEnable = 1'b0; loaderValid = 1'b0; loaderDone = 1'b0;
  endtask

  task automatic fetchCycle(input logic [31:0] pc, input logic [31:0] expWord);
    fetchEnable = 1'b1; fetchAddress = pc; loaderValid = 1'b0;
    #1;
    chk("fetch_nostall", {31'b0, fetchStall}, 32'd0);
    expQ.push_back(expWord);
    @(negedge clock);
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_WIDTH); i++) mem[i] = 32'h0;
    reset = 1'b1; fetchEnable = 1'b1; fetchAddress = 32'h0;
    loaderValid = 1'b1; loaderAddress = 32'h0; loaderData = 32'h0; loaderDone = 1'b0;
    #3;
    chk("rst_bootDone", {31'b0, bootDone}, 32'd0);
    chk("rst_fetchStall", {31'b0, fetchStall}, 32'd1);
    chk("rst_loaderReady", {31'b0, loaderReady}, 32'd1);
    chk("rst_memWriteEnable", {31'b0, memWriteEnable}, 32'd0);
    chk("rst_fetchDataValid", {31'b0, fetchDataValid}, 32'd0);

    // Boot load of words 0..3 while fetch is requesting.
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      loaderValid = 1'b1; loaderAddress = 32'(i * 4); loaderData = 32'(8'h11 * (i + 1));
      #1;
      chk("boot_fetchStall", {31'b0, fetchStall}, 32'd1);
      chk("boot_loaderReady", {31'b0, loaderReady}, 32'd1);
      chk("boot_memWriteEnable", {31'b0, memWriteEnable}, 32'd1);
      @(negedge clock);
    end
    loaderValid = 1'b0; loaderDone = 1'b1;
    #1 chk("boot_stall_done", {31'b0, fetchStall}, 32'd1);
    @(negedge clock);
    loaderDone = 1'b0;
    chk("run_bootDone", {31'b0, bootDone}, 32'd1);
    fetchCycle(32'd8, 32'h33);

    // Idle-fetch loader write is granted at once.
    fetchEnable = 1'b0; loaderValid = 1'b1; loaderAddress = 32'h40; loaderData = 32'hAA;
    #1;
    chk("idle_loaderReady", {31'b0, loaderReady}, 32'd1);
    chk("idle_fetchStall", {31'b0, fetchStall}, 32'd0);
    chk("idle_starve", 32'(dut.starveCount), 32'd0);
    @(negedge clock);
    chk("idle_starve_after", 32'(dut.starveCount), 32'd0);

    // Starvation: denied four cycles, forced through on the fifth.
    fetchEnable = 1'b1; fetchAddress = 32'h0;
    loaderValid = 1'b1; loaderAddress = 32'h44; loaderData = 32'hBB;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("starve_loaderReady", {31'b0, loaderReady}, (c == 4) ? 32'd1 : 32'd0);
      chk("starve_fetchStall", {31'b0, fetchStall}, (c == 4) ? 32'd1 : 32'd0);
      if (c < 4) expQ.push_back(32'h11);
      @(negedge clock);
    end
    loaderValid = 1'b0;
    #1 chk("starve_fdv_after_grant", {31'b0, fetchDataValid}, 32'd0);
    chk("starve_stall_released", {31'b0, fetchStall}, 32'd0);
    expQ.push_back(32'h11);
    @(negedge clock);
    fetchCycle(32'h44, 32'hBB);
    fetchCycle(32'h40, 32'hAA);

    // Wrap and misalignment: 0x1003 lands on word 0, read back immediately.
    idle();
    loaderValid = 1'b1; loaderAddress = 32'h1003; loaderData = 32'hDEAD;
    #1 chk("wrap_memAddress", 32'(memAddress), 32'd0);
    @(negedge clock);
    fetchCycle(32'h0, 32'hDEAD);

    // loaderDone in RUN is ignored.
    loaderDone = 1'b1;
    fetchCycle(32'h4, 32'h22);
    loaderDone = 1'b0;
    chk("run_done_ignored", {31'b0, bootDone}, 32'd1);

    // Asynchronous reset mid-RUN over a granted write: write dropped.
    fetchEnable = 1'b0; loaderValid = 1'b1; loaderAddress = 32'h8; loaderData = 32'h99;
    #2 reset = 1'b1;
    #1;
    chk("arst_bootDone", {31'b0, bootDone}, 32'd0);
    chk("arst_fetchStall", {31'b0, fetchStall}, 32'd1);
    chk("arst_fdv", {31'b0, fetchDataValid}, 32'd0);
    chk("arst_memWriteEnable", {31'b0, memWriteEnable}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Back in BOOT: write together with loaderDone.
    fetchEnable = 1'b1; loaderValid = 1'b1; loaderAddress = 32'h20; loaderData = 32'h55;
    loaderDone = 1'b1;
    #1;
    chk("reboot_loaderReady", {31'b0, loaderReady}, 32'd1);
    chk("reboot_memWriteEnable", {31'b0, memWriteEnable}, 32'd1);
    chk("reboot_fetchStall", {31'b0, fetchStall}, 32'd1);
    @(negedge clock);
    loaderDone = 1'b0;
    chk("reboot_bootDone", {31'b0, bootDone}, 32'd1);
    fetchCycle(32'h20, 32'h55);
    fetchCycle(32'h8, 32'h33);

    idle();
    repeat (3) @(negedge clock);
    chk("scoreboard_drained", 32'(expQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/instruction_memory_arbiter.md
# instruction_memory_arbiter

Shares the single-port instruction memory between the fetch stage, which reads one instruction word per cycle, and a program loader, which writes words over a valid/ready handshake. After reset the block holds fetch stalled and lets the loader fill the memory (BOOT). Once the loader signals completion, fetch owns the port (RUN), and later loader writes are granted in fetch-idle cycles or forced through by a starvation limit. It sits between the program counter / fetch register logic and the instruction memory macro.

## Interface
Parameters:
- ADDR_WIDTH, 10, word-address width of the instruction memory
- STARVE_LIMIT, 4, maximum consecutive cycles a pending loader write may be denied in RUN (≥1)

Ports:
- clock  in  1  system clock, all state on posedge
- reset  in  1  asynchronous, active-high; clears all state immediately
- fetchEnable  in  1  fetch requests a read this cycle (driven as !stallOnDecode)
- fetchAddress  in  32  byte program counter; bits [ADDR_WIDTH+1:2] are used
- fetchStall  out  1  fetch must hold its PC and pipeline register this cycle
- fetchData  out  32  instruction word, passthrough of memReadData
- fetchDataValid  out  1  fetchData holds the word for the read granted in the previous cycle
- loaderValid  in  1  loader write request
- loaderAddress  in  32  byte address of the write; bits [ADDR_WIDTH+1:2] are used
- loaderData  in  32  write data
- loaderReady  out  1  write accepted this cycle (transfer = loaderValid & loaderReady)
- loaderDone  in  1  single-cycle pulse: program load complete
- bootDone  out  1  high in RUN
- memAddress  out  ADDR_WIDTH  word address to the memory
- memWriteEnable  out  1  write strobe
- memWriteData  out  32  write data
- memReadData  in  32  synchronous read data, one-cycle latency

## Operation
- States: BOOT (reset state) and RUN. RUN is left only through reset.
- BOOT:
  - fetchStall=1, loaderReady=1.
  - memWriteEnable=loaderValid; memAddress and memWriteData come from the loader.
  - loaderDone moves the block to RUN on the next edge. A write in the same cycle as loaderDone still completes.
- RUN grant:
  - loaderGrant = loaderValid & (!fetchEnable | starveCount ≥ STARVE_LIMIT).
  - If loaderGrant: loaderReady=1, memWriteEnable=1, loader address and data drive the memory, and fetchStall=fetchEnable.
  - Otherwise: fetchStall=0, loaderReady=0, memWriteEnable=0, and memAddress comes from fetchAddress.
  - memAddress comes from fetchAddress even when fetchEnable=0 (harmless read).
- starveCount (width ⌈log2(STARVE_LIMIT+1)⌉):
  - Cleared on grant, and whenever loaderValid=0.
  - Incremented, saturating at STARVE_LIMIT, when loaderValid=1 is denied in RUN.
  - Held at 0 in BOOT.
- fetchDataValid is registered: next value = (state==RUN) & fetchEnable & !loaderGrant.
- Address handling:
  - Address bits above ADDR_WIDTH+1 are ignored, so addresses wrap modulo memory size.
  - Bits [1:0] are ignored, so misaligned addresses round down.
- loaderDone in RUN is ignored.
- A loader write and a fetch read to the same word in consecutive cycles: the read returns the new data. The read follows the write in port order.

## Timing
- Reset values: state=BOOT, starveCount=0, fetchDataValid=0. While reset is high, bootDone=0, fetchStall=1, loaderReady=1, and memWriteEnable=0 (gated by reset).
- Reset asserted mid-RUN returns the block to BOOT asynchronously; the pending write of that cycle is dropped.
- Read latency: the address is presented in cycle N, and fetchData/fetchDataValid are valid in cycle N+1.
- Write: takes effect at the edge ending the transfer cycle; there is no backpressure beyond loaderReady.
- Worst-case loader wait in RUN with fetchEnable held high is STARVE_LIMIT denied cycles, then a grant in the next cycle.
- Worst-case fetch loss is one stall cycle per forced grant. With loaderValid held continuously, at most one stall occurs every STARVE_LIMIT+1 cycles.
- BOOT→RUN: fetch gets its first grant in the cycle after loaderDone, and its first fetchDataValid one cycle later.

## Test plan
- Reset then boot load: write words 0..3 with data 0x11..0x44 at byte addresses 0,4,8,12, then pulse loaderDone. Required: fetchStall=1 throughout, then bootDone=1. Fetch at PC 8 returns 0x33 with fetchDataValid=1 one cycle after the request.
- RUN with fetchEnable=0 and loaderValid=1: loaderReady=1 in the same cycle, fetchStall=0, starveCount stays 0.
- Starvation with STARVE_LIMIT=4, fetchEnable held 1, loaderValid held 1 from cycle 0: denied in cycles 0–3, granted in cycle 4 with fetchStall=1 in cycle 4 only. fetchDataValid=0 in cycle 5.
- Wrap and alignment with ADDR_WIDTH=10: a loader write to byte address 0x1003 with 0xDEAD lands at word 0. Fetch at PC 0x0 then returns 0xDEAD.
- loaderDone in the same cycle as a write to address 0x20: the write is stored and the state becomes RUN. A second loaderDone in RUN causes no change.
- Asynchronous reset pulse mid-RUN, between clock edges: bootDone drops and fetchStall rises immediately, and fetchDataValid=0. The block is back in BOOT and accepts loader writes on the next edge.
